// File: rtl/adia_rx_capture.sv
// Captures one dual-rail word per power-clock HOLD interval into a 2-entry FIFO.
// It also tracks sticky rail, overflow and phase-sequence error state.
module adia_rx_capture #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       phase,
  input  logic [WIDTH-1:0] in_t,
  input  logic [WIDTH-1:0] in_f,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_rail,
  output logic             err_ovf,
  output logic             err_seq,
  output logic [7:0]       err_cnt,
  input  logic             err_clr
);

  localparam logic [1:0] PhHold = 2'b01;
  localparam logic [1:0] PhWait = 2'b11;

  logic [1:0]       phase_q;
  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             err_rail_q, err_rail_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_seq_q, err_seq_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic capture, well_formed, pop, push, ovf_event, rail_event, seq_event;

  always_comb begin
    capture     = (phase == PhHold) && (phase_q != PhHold);
    well_formed = (in_t == ~in_f);
    pop         = (count_q != 2'd0) && out_ready;
    // A full FIFO still accepts the word when the head leaves on the same edge.
    push        = capture && well_formed && ((count_q != 2'd2) || pop);
    ovf_event   = capture && well_formed && (count_q == 2'd2) && !out_ready;
    rail_event  = capture && !well_formed;
    // Legal moves are "no change" or advancing by one phase modulo 4.
    seq_event   = (phase != phase_q) && (phase != phase_q + 2'd1);
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    err_rail_d = err_rail_q | rail_event;
    err_ovf_d  = err_ovf_q | ovf_event;
    err_seq_d  = err_seq_q | seq_event;
    err_cnt_d  = err_cnt_q;
    if (err_clr) begin
      // An error arriving on the clear edge wins over the clear.
      err_rail_d = rail_event;
      err_ovf_d  = ovf_event;
      err_seq_d  = seq_event;
      err_cnt_d  = rail_event ? 8'd1 : 8'd0;
    end else if (rail_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PhWait;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      err_rail_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_seq_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      phase_q    <= phase;
      count_q    <= count_d;
      err_rail_q <= err_rail_d;
      err_ovf_q  <= err_ovf_d;
      err_seq_q  <= err_seq_d;
      err_cnt_q  <= err_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_t;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != 2'd0);
  assign err_rail  = err_rail_q;
  assign err_ovf   = err_ovf_q;
  assign err_seq   = err_seq_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_adia_rx_capture.sv
// Directed self-checking bench for adia_rx_capture; inputs change 1 time unit after each
// rising edge and outputs are sampled at that same point.
module tb_adia_rx_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  phase;
  logic [31:0] in_t, in_f;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic        err_rail, err_ovf, err_seq, err_clr;
  logic [7:0]  err_cnt;

  int tests = 0;
  int fails = 0;

  adia_rx_capture #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .phase(phase), .in_t(in_t), .in_f(in_f),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_rail(err_rail), .err_ovf(err_ovf), .err_seq(err_seq),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [1:0] ph);
    phase = ph;
    @(posedge clk);
    #1;
  endtask

  // Full RAMP_UP/HOLD/RAMP_DOWN/WAIT cycle capturing one word.
  task automatic capture_word(input logic [31:0] t, input logic [31:0] f);
    in_t = t; in_f = f;
    cyc(2'b00); cyc(2'b01); cyc(2'b10); cyc(2'b11);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1; cyc(2'b11); err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; phase = 2'b11; in_t = '0; in_f = '1; out_ready = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h exp 0", out_data); end
    tests++; if ({err_rail, err_ovf, err_seq} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {err_rail, err_ovf, err_seq}); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", err_cnt); end
    #3 rst_n = 1'b1;
    cyc(2'b11);
  endtask

  task automatic test_nominal();
    int pulses = 0;
    out_ready = 1'b1; in_t = 32'hA5A5A5A5; in_f = 32'h5A5A5A5A;
    cyc(2'b00); if (out_valid) pulses++;
    cyc(2'b01);
    tests++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5) begin fails++; $display("FAIL nominal_capture got v=%b d=%h exp v=1 d=a5a5a5a5", out_valid, out_data); end
    if (out_valid) pulses++;
    cyc(2'b01); if (out_valid) pulses++;
    cyc(2'b10); if (out_valid) pulses++;
    cyc(2'b11); if (out_valid) pulses++;
    tests++; if (pulses != 1) begin fails++; $display("FAIL nominal_pulses got %0d exp 1", pulses); end
    tests++; if ({err_rail, err_ovf, err_seq} !== 3'b000) begin fails++; $display("FAIL nominal_errs got %b exp 000", {err_rail, err_ovf, err_seq}); end
  endtask

  task automatic test_rail_error();
    out_ready = 1'b1; in_t = 32'h1; in_f = 32'h1;
    cyc(2'b00); cyc(2'b01);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rail_valid got %b exp 0", out_valid); end
    tests++; if (err_rail !== 1'b1 || err_cnt !== 8'd1) begin fails++; $display("FAIL rail_first got rail=%b cnt=%0d exp rail=1 cnt=1", err_rail, err_cnt); end
    cyc(2'b10); cyc(2'b11);
    for (int i = 0; i < 299; i++) capture_word(32'h1, 32'h1);
    tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL rail_saturate got %0d exp 255", err_cnt); end
    tests++; if (err_ovf !== 1'b0 || err_seq !== 1'b0) begin fails++; $display("FAIL rail_other got ovf=%b seq=%b exp 0 0", err_ovf, err_seq); end
    clear_errors();
    tests++; if ({err_rail, err_cnt} !== 9'd0) begin fails++; $display("FAIL rail_clear got rail=%b cnt=%0d exp 0 0", err_rail, err_cnt); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    capture_word(32'h1, ~32'h1);
    capture_word(32'h2, ~32'h2);
    tests++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_full_no_drop got %b exp 0", err_ovf); end
    capture_word(32'h3, ~32'h3);
    tests++; if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", err_ovf); end
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin fails++; $display("FAIL ovf_hold got v=%b d=%h exp v=1 d=1", out_valid, out_data); end
    out_ready = 1'b1;
    cyc(2'b11);
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h2) begin fails++; $display("FAIL ovf_pop2 got v=%b d=%h exp v=1 d=2", out_valid, out_data); end
    cyc(2'b11);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty got %b exp 0", out_valid); end
    clear_errors();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    capture_word(32'h1, ~32'h1);
    capture_word(32'h2, ~32'h2);
    in_t = 32'h3; in_f = ~32'h3;
    cyc(2'b00);
    out_ready = 1'b1;
    #0;
    tests++; if (out_data !== 32'h1) begin fails++; $display("FAIL b2b_head got %h exp 1", out_data); end
    cyc(2'b01);
    tests++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL b2b_no_ovf got %b exp 0", err_ovf); end
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h2) begin fails++; $display("FAIL b2b_pop2 got v=%b d=%h exp v=1 d=2", out_valid, out_data); end
    cyc(2'b01);
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h3) begin fails++; $display("FAIL b2b_pop3 got v=%b d=%h exp v=1 d=3", out_valid, out_data); end
    cyc(2'b10);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty got %b exp 0", out_valid); end
    cyc(2'b11);
  endtask

  task automatic test_seq_clear();
    out_ready = 1'b1;
    cyc(2'b00); cyc(2'b10);
    tests++; if (err_seq !== 1'b1) begin fails++; $display("FAIL seq_set got %b exp 1", err_seq); end
    err_clr = 1'b1; cyc(2'b10); err_clr = 1'b0;
    tests++; if (err_seq !== 1'b0) begin fails++; $display("FAIL seq_clear got %b exp 0", err_seq); end
    cyc(2'b11);
    capture_word(32'h5, 32'h4);
    capture_word(32'h5, 32'h4);
    tests++; if (err_cnt !== 8'd2) begin fails++; $display("FAIL seq_precnt got %0d exp 2", err_cnt); end
    in_t = 32'h1; in_f = 32'h1;
    cyc(2'b00);
    err_clr = 1'b1; cyc(2'b01); err_clr = 1'b0;
    tests++; if (err_rail !== 1'b1 || err_cnt !== 8'd1) begin fails++; $display("FAIL clr_vs_err got rail=%b cnt=%0d exp rail=1 cnt=1", err_rail, err_cnt); end
    cyc(2'b10); cyc(2'b11);
    clear_errors();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    capture_word(32'h1, ~32'h1);
    capture_word(32'h2, ~32'h2);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_reset got %b exp 0", out_valid); end
    phase = 2'b01; in_t = 32'h77; in_f = ~32'h77;
    @(posedge clk); #4 rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin fails++; $display("FAIL release_capture got v=%b d=%h exp v=1 d=77", out_valid, out_data); end
    tests++; if (err_seq !== 1'b1) begin fails++; $display("FAIL release_seq got %b exp 1", err_seq); end
    in_t = 32'h88; in_f = ~32'h88;
    cyc(2'b01);
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin fails++; $display("FAIL hold_single got v=%b d=%h exp v=1 d=77", out_valid, out_data); end
    out_ready = 1'b1;
    cyc(2'b01);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_discard got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_rail_error();
    test_overflow();
    test_back_to_back();
    test_seq_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
